// File: rtl/apb_requester_arb.sv
// Two-port APB3 requester: round-robin arbitration between two local command ports,
// SETUP/ACCESS sequencing toward one completer, and a bounded wait-state timeout.
module apb_requester_arb #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,

    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                ptr_q, ptr_d;
    logic                gnt_q, gnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                rsp0_valid_q, rsp0_valid_d;
    logic [DATA_W-1:0]   rsp0_rdata_q, rsp0_rdata_d;
    logic                rsp0_err_q, rsp0_err_d;
    logic                rsp1_valid_q, rsp1_valid_d;
    logic [DATA_W-1:0]   rsp1_rdata_q, rsp1_rdata_d;
    logic                rsp1_err_q, rsp1_err_d;

    logic                take_c;
    logic                grant_c;
    logic                done_c;
    logic [DATA_W-1:0]   done_rdata_c;
    logic                done_err_c;

    // Next-state, arbitration and response steering.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        cnt_d        = cnt_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        paddr_d      = paddr_q;
        pwrite_d     = pwrite_q;
        pwdata_d     = pwdata_q;
        rsp0_valid_d = 1'b0;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp0_err_d   = rsp0_err_q;
        rsp1_valid_d = 1'b0;
        rsp1_rdata_d = rsp1_rdata_q;
        rsp1_err_d   = rsp1_err_q;
        take_c       = 1'b0;
        grant_c      = 1'b0;
        done_c       = 1'b0;
        done_rdata_c = '0;
        done_err_c   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    take_c    = 1'b1;
                    grant_c   = (req0_valid && req1_valid) ? ptr_q : req1_valid;
                    ptr_d     = ~grant_c;
                    gnt_d     = grant_c;
                    paddr_d   = grant_c ? req1_addr  : req0_addr;
                    pwrite_d  = grant_c ? req1_write : req0_write;
                    pwdata_d  = grant_c ? req1_wdata : req0_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                penable_d = 1'b1;
                state_d   = S_ACCESS;
            end
            S_ACCESS: begin
                if (pready) begin
                    done_c       = 1'b1;
                    done_rdata_c = pwrite_q ? '0 : prdata;
                    done_err_c   = pslverr;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    done_c     = 1'b1;
                    done_err_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Completion or abort: release the bus and pulse the owner's response.
        if (done_c) begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = S_IDLE;
            if (gnt_q) begin
                rsp1_valid_d = 1'b1;
                rsp1_rdata_d = done_rdata_c;
                rsp1_err_d   = done_err_c;
            end else begin
                rsp0_valid_d = 1'b1;
                rsp0_rdata_d = done_rdata_c;
                rsp0_err_d   = done_err_c;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q      <= S_IDLE;
            ptr_q        <= 1'b0;
            gnt_q        <= 1'b0;
            cnt_q        <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            paddr_q      <= '0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
            rsp0_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp0_err_q   <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp1_rdata_q <= '0;
            rsp1_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            cnt_q        <= cnt_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            paddr_q      <= paddr_d;
            pwrite_q     <= pwrite_d;
            pwdata_q     <= pwdata_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp0_err_q   <= rsp0_err_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp1_rdata_q <= rsp1_rdata_d;
            rsp1_err_q   <= rsp1_err_d;
        end
    end

    // Ready is a same-cycle grant; suppressed while reset is held.
    assign req0_ready = take_c && !grant_c && !preset;
    assign req1_ready = take_c &&  grant_c && !preset;

    assign psel       = psel_q;
    assign penable    = penable_q;
    assign paddr      = paddr_q;
    assign pwrite     = pwrite_q;
    assign pwdata     = pwdata_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp0_err   = rsp0_err_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp1_rdata = rsp1_rdata_q;
    assign rsp1_err   = rsp1_err_q;

endmodule

// File: tb/tb_apb_requester_arb.sv
// Self-checking bench for apb_requester_arb: transaction-level model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_apb_requester_arb;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 16;

    logic              pclk = 1'b0;
    logic              preset = 1'b1;
    logic              req0_valid = 1'b0, req0_write = 1'b0;
    logic [ADDR_W-1:0] req0_addr = '0;
    logic [DATA_W-1:0] req0_wdata = '0;
    logic              req1_valid = 1'b0, req1_write = 1'b0;
    logic [ADDR_W-1:0] req1_addr = '0;
    logic [DATA_W-1:0] req1_wdata = '0;
    logic [DATA_W-1:0] prdata = '0;
    logic              pready = 1'b0, pslverr = 1'b0;
    logic              req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [DATA_W-1:0] rsp0_rdata, rsp1_rdata, pwdata;
    logic [ADDR_W-1:0] paddr;
    logic              psel, penable, pwrite;

    always #5 pclk = ~pclk;

    apb_requester_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .preset(preset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding command, m_k = cycles since acceptance.
    bit                armed = 1'b0;
    bit                m_busy = 1'b0;
    int                m_k = 0;
    bit                m_own = 1'b0;
    bit                m_ptr = 1'b0;
    bit                m_wr = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_wdata = '0;
    bit                m_rv [2];
    logic [DATA_W-1:0] m_rd [2];
    bit                m_er [2];
    int                acc_n [2];
    int                cyc = 0;
    int                acc_run = 0;
    int                grants [$];
    int                acc_cyc [$];

    // Completer behaviour: 0 = fixed wait count, 2 = never ready, 3 = random.
    int                cmp_mode = 0;
    int                cmp_nwait = 0;
    int                cmp_idx = 0;
    logic [DATA_W-1:0] cmp_rdata = '0;
    bit                cmp_err = 1'b0;

    task automatic model_cycle();
        bit v0, v1, g, take;
        cyc++;
        v0   = req0_valid;
        v1   = req1_valid;
        take = !m_busy && !preset && (v0 || v1);
        g    = (v0 && v1) ? m_ptr : v1;
        if (armed) begin
            chk("req0_ready", req0_ready, take && !g);
            chk("req1_ready", req1_ready, take && g);
            chk("psel", psel, m_busy);
            chk("penable", penable, m_busy && m_k >= 2);
            chk("paddr", paddr, m_addr);
            chk("pwrite", pwrite, m_wr);
            chk("pwdata", pwdata, m_wdata);
            chk("rsp0_valid", rsp0_valid, m_rv[0]);
            chk("rsp0_rdata", rsp0_rdata, m_rd[0]);
            chk("rsp0_err", rsp0_err, m_er[0]);
            chk("rsp1_valid", rsp1_valid, m_rv[1]);
            chk("rsp1_rdata", rsp1_rdata, m_rd[1]);
            chk("rsp1_err", rsp1_err, m_er[1]);
        end
        if (req0_ready === 1'b1) begin grants.push_back(0); acc_cyc.push_back(cyc); end
        if (req1_ready === 1'b1) begin grants.push_back(1); acc_cyc.push_back(cyc); end
        if (penable === 1'b1) acc_run++; else acc_run = 0;

        m_rv[0] = 1'b0;
        m_rv[1] = 1'b0;
        if (preset) begin
            m_busy = 1'b0; m_k = 0; m_ptr = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
            for (int p = 0; p < 2; p++) begin m_rd[p] = '0; m_er[p] = 1'b0; end
        end else if (take) begin
            m_busy  = 1'b1;
            m_k     = 1;
            m_own   = g;
            m_ptr   = !g;
            m_wr    = g ? req1_write : req0_write;
            m_addr  = g ? req1_addr  : req0_addr;
            m_wdata = g ? req1_wdata : req0_wdata;
            acc_n[g]++;
        end else if (m_busy) begin
            if (m_k >= 2 && pready) begin
                m_busy = 1'b0;
                m_rv[m_own] = 1'b1;
                m_rd[m_own] = m_wr ? '0 : prdata;
                m_er[m_own] = pslverr;
            end else if (m_k - 1 == int'(TIMEOUT)) begin
                m_busy = 1'b0;
                m_rv[m_own] = 1'b1;
                m_rd[m_own] = '0;
                m_er[m_own] = 1'b1;
            end else begin
                m_k++;
            end
        end
    endtask

    task automatic drive_completer();
        if (psel === 1'b1 && penable === 1'b1) begin
            pready  = (cmp_mode == 2) ? 1'b0 : (cmp_idx >= cmp_nwait);
            cmp_idx++;
            prdata  = (cmp_mode == 3) ? $urandom : cmp_rdata;
            pslverr = (cmp_mode == 3) ? ($urandom_range(0, 3) == 0) : cmp_err;
        end else begin
            cmp_idx = 0;
            if (cmp_mode == 3)
                cmp_nwait = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 3));
            pready  = 1'($urandom_range(0, 1));
            prdata  = $urandom;
            pslverr = 1'($urandom_range(0, 1));
        end
    endtask

    // One clock: compare/update at the falling edge, then drive the completer after the rise.
    task automatic tick();
        @(negedge pclk);
        model_cycle();
        @(posedge pclk);
        #1;
        drive_completer();
    endtask

    task automatic set_req(input int p, input bit wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        if (p == 0) begin req0_valid = 1'b1; req0_write = wr; req0_addr = a; req0_wdata = d; end
        else        begin req1_valid = 1'b1; req1_write = wr; req1_addr = a; req1_wdata = d; end
    endtask

    task automatic send(input int p, input bit wr, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
        int c0 = acc_n[p];
        set_req(p, wr, a, d);
        for (int i = 0; i < 60 && acc_n[p] == c0; i++) tick();
        chk("send_accepted", acc_n[p] != c0, 1'b1);
        if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int p, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            #1;
            if ((p == 0 && rsp0_valid === 1'b1) || (p == 1 && rsp1_valid === 1'b1)) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        bit ok;
        int seen [2];
        int b0, b1;
        for (int p = 0; p < 2; p++) begin m_rv[p] = 0; m_rd[p] = '0; m_er[p] = 0; acc_n[p] = 0; end

        repeat (3) tick();
        preset = 1'b0;
        armed  = 1'b1;
        #1;
        chk("reset_psel", psel, 1'b0);
        chk("reset_penable", penable, 1'b0);
        chk("reset_paddr", paddr, 8'h00);
        chk("reset_rsp0_rdata", rsp0_rdata, 32'h0);
        chk("reset_rsp1_err", rsp1_err, 1'b0);

        // Zero-wait write from port 0, cycle by cycle.
        cmp_mode = 0; cmp_nwait = 0; cmp_err = 1'b0;
        set_req(0, 1'b1, 8'h04, 32'hDEADBEEF);
        #1;
        chk("t1_c0_ready", req0_ready, 1'b1);
        chk("t1_c0_psel", psel, 1'b0);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("t1_c1_psel", psel, 1'b1);
        chk("t1_c1_penable", penable, 1'b0);
        chk("t1_c1_paddr", paddr, 8'h04);
        chk("t1_c1_pwdata", pwdata, 32'hDEADBEEF);
        tick();
        #1;
        chk("t1_c2_penable", penable, 1'b1);
        tick();
        #1;
        chk("t1_c3_rsp0_valid", rsp0_valid, 1'b1);
        chk("t1_c3_rsp0_err", rsp0_err, 1'b0);
        chk("t1_c3_rsp0_rdata", rsp0_rdata, 32'h0);
        chk("t1_c3_psel", psel, 1'b0);

        // Read from port 1 with three wait states.
        cmp_nwait = 3; cmp_rdata = 32'h12345678;
        send(1, 1'b0, 8'h08, 32'h0);
        wait_rsp(1, 30, ok);
        chk("t2_rsp_seen", ok, 1'b1);
        chk("t2_access_len", acc_run, 4);
        chk("t2_rdata", rsp1_rdata, 32'h12345678);
        chk("t2_err", rsp1_err, 1'b0);

        // Both ports continuously valid, four zero-wait transfers each.
        cmp_nwait = 0;
        grants.delete(); acc_cyc.delete();
        b0 = acc_n[0]; b1 = acc_n[1]; seen[0] = b0; seen[1] = b1;
        set_req(0, 1'b1, 8'h10, $urandom);
        set_req(1, 1'b0, 8'h20, $urandom);
        for (int i = 0; i < 60 && (acc_n[0] - b0 < 4 || acc_n[1] - b1 < 4 || m_busy); i++) begin
            tick();
            if (acc_n[0] - b0 >= 4) req0_valid = 1'b0;
            else if (acc_n[0] != seen[0]) begin
                seen[0] = acc_n[0];
                set_req(0, 1'($urandom_range(0, 1)), 8'($urandom), $urandom);
            end
            if (acc_n[1] - b1 >= 4) req1_valid = 1'b0;
            else if (acc_n[1] != seen[1]) begin
                seen[1] = acc_n[1];
                set_req(1, 1'($urandom_range(0, 1)), 8'($urandom), $urandom);
            end
        end
        chk("t3_grant_count", grants.size(), 8);
        for (int i = 0; i < grants.size(); i++) chk("t3_grant_order", grants[i], i % 2);
        for (int i = 1; i < acc_cyc.size(); i++) chk("t3_grant_spacing", acc_cyc[i] - acc_cyc[i-1], 3);

        // Slave error on a write.
        cmp_err = 1'b1;
        send(1, 1'b1, 8'h0C, 32'hCAFEF00D);
        wait_rsp(1, 30, ok);
        chk("t4_rsp_seen", ok, 1'b1);
        chk("t4_err", rsp1_err, 1'b1);
        chk("t4_psel_dropped", psel, 1'b0);
        cmp_err = 1'b0;

        // Completer never ready: abort after TIMEOUT access cycles.
        cmp_mode = 2;
        send(0, 1'b0, 8'h30, 32'h0);
        wait_rsp(0, 40, ok);
        chk("t5_rsp_seen", ok, 1'b1);
        chk("t5_access_len", acc_run, 16);
        chk("t5_err", rsp0_err, 1'b1);
        chk("t5_rdata", rsp0_rdata, 32'h0);
        chk("t5_psel", psel, 1'b0);
        chk("t5_penable", penable, 1'b0);
        cmp_mode = 0; cmp_rdata = 32'h0BADF00D;
        send(1, 1'b0, 8'h34, 32'h0);
        wait_rsp(1, 30, ok);
        chk("t5_next_ok", ok, 1'b1);
        chk("t5_next_rdata", rsp1_rdata, 32'h0BADF00D);

        // Reset in ACCESS with the pointer pointing at port 1.
        cmp_mode = 2;
        send(0, 1'b1, 8'h40, 32'h11111111);
        for (int i = 0; i < 5 && !(m_busy && m_k >= 3); i++) tick();
        chk("t6_in_access", penable, 1'b1);
        preset = 1'b1;
        tick();
        preset = 1'b0;
        #1;
        chk("t6_psel", psel, 1'b0);
        chk("t6_penable", penable, 1'b0);
        chk("t6_rsp0_valid", rsp0_valid, 1'b0);
        chk("t6_rsp0_err", rsp0_err, 1'b0);
        cmp_mode = 0; cmp_nwait = 0; cmp_rdata = 32'hA5A50001;
        grants.delete();
        set_req(0, 1'b0, 8'h44, 32'h0);
        set_req(1, 1'b0, 8'h48, 32'h0);
        b0 = acc_n[0];
        for (int i = 0; i < 10 && acc_n[0] == b0; i++) tick();
        req0_valid = 1'b0;
        chk("t6_first_grant", (grants.size() > 0) ? grants[0] : -1, 0);
        wait_rsp(0, 10, ok);
        chk("t6_rsp_ok", ok, 1'b1);
        chk("t6_rdata", rsp0_rdata, 32'hA5A50001);
        for (int i = 0; i < 20 && req1_valid; i++) begin
            tick();
            if (acc_n[1] != b1) req1_valid = 1'b0;
            b1 = acc_n[1];
        end

        // Randomized traffic against the model.
        cmp_mode = 3;
        seen[0] = acc_n[0]; seen[1] = acc_n[1];
        for (int i = 0; i < 600; i++) begin
            tick();
            if (acc_n[0] != seen[0]) begin seen[0] = acc_n[0]; req0_valid = 1'b0; end
            if (acc_n[1] != seen[1]) begin seen[1] = acc_n[1]; req1_valid = 1'b0; end
            if (!req0_valid && $urandom_range(0, 2) == 0)
                set_req(0, 1'($urandom_range(0, 1)), 8'($urandom), $urandom);
            if (!req1_valid && $urandom_range(0, 2) == 0)
                set_req(1, 1'($urandom_range(0, 1)), 8'($urandom), $urandom);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cmp_mode = 0; cmp_nwait = 0;
        for (int i = 0; i < 40 && m_busy; i++) tick();
        chk("drain_idle", m_busy, 1'b0);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_requester_arb.md
Name: apb_requester_arb

Overview:
- Two-port APB3 requester. Accepts read/write commands from two local requesters, arbitrates round-robin, and sequences the SETUP/ACCESS phases toward a single `apb_completer`.
- Returns read data and error status to the requester that issued the command.
- Bounds completer wait states with a programmable timeout.
- Sits between on-chip masters and the APB completer; it is the sole driver of the completer's APB inputs.

Parameters:
- ADDR_W, 8, APB address width
- DATA_W, 32, APB data width
- TIMEOUT, 16, maximum consecutive ACCESS cycles with pready=0 before abort (must be >=2)

Ports:
- pclk  in  1  clock; all logic on rising edge
- preset  in  1  synchronous reset, active-high
- req0_valid  in  1  requester 0 command valid
- req0_ready  out  1  requester 0 command accepted this cycle
- req0_write  in  1  1=write, 0=read
- req0_addr  in  ADDR_W  command address
- req0_wdata  in  DATA_W  write data
- rsp0_valid  out  1  one-cycle response pulse to requester 0
- rsp0_rdata  out  DATA_W  read data (0 for writes and aborts)
- rsp0_err  out  1  pslverr or timeout
- req1_*/rsp1_*  same set as port 0, for requester 1
- paddr  out  ADDR_W  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB slave error

Behaviour:
- Reset (preset=1 at an edge):
  - State=IDLE, round-robin pointer=0.
  - Wait counter=0.
  - All outputs 0: psel, penable, paddr, pwrite, pwdata, req*_ready, rsp*_valid, rsp*_rdata, rsp*_err.
- Reset mid-transfer: psel/penable are 0 from the next edge, no response is issued, and the captured command is discarded.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - Grant requester g among valid requesters. If both are valid, g=pointer; otherwise g is the sole valid one.
  - reqg_ready=1 combinationally in the same cycle; the command is captured at that edge.
  - On capture: pointer<=~g, next state=SETUP.
  - req*_ready is 0 outside IDLE.
  - Requesters hold command fields stable while valid && !ready.
- SETUP (exactly 1 cycle):
  - psel=1, penable=0.
  - paddr/pwrite/pwdata come from the captured command, registered and stable through ACCESS.
  - Next state=ACCESS.
- ACCESS:
  - psel=1, penable=1.
  - On pready=1: capture prdata (reads only, else 0) and pslverr. Next edge: psel=penable=0, state=IDLE, rspg_valid=1 for one cycle with rdata/err.
  - On pready=0: wait counter++.
  - Abort: if the counter reaches TIMEOUT-1 and pready is still 0, the next edge drops psel/penable, and rspg_valid=1 with err=1, rdata=0.
  - The counter clears on SETUP entry.
- Throughput:
  - Zero-wait transfer: 3 cycles (accept, SETUP, ACCESS).
  - Response pulse coincides with the next IDLE cycle; a new command may be accepted in that same cycle.
- rsp*_rdata/err hold their last values between pulses; only rsp*_valid qualifies them.
- Only one transfer is outstanding; the non-granted requester waits with ready=0.
- Simultaneous continuous requests alternate strictly 0,1,0,1...

Test Plan:
- Reset then req0 write addr=0x04 wdata=0xDEADBEEF, pready=1 -> req0_ready at cycle 0; psel=1/penable=0 at cycle 1; penable=1 at cycle 2; rsp0_valid=1, err=0, rdata=0 at cycle 3.
- req1 read addr=0x08, pready low 3 ACCESS cycles then high with prdata=0x12345678 -> ACCESS lasts 4 cycles; rsp1_rdata=0x12345678, err=0; paddr stable throughout.
- req0 and req1 valid continuously, 4 transfers each, zero-wait -> grant order 0,1,0,1,...; no rsp on the wrong port; one transfer every 3 cycles.
- Write with pslverr=1 on the pready cycle -> rsp_err=1, psel drops next edge.
- pready held 0 with TIMEOUT=16 -> 16 ACCESS cycles, then psel=penable=0, rsp_valid=1, err=1, rdata=0; the next request is accepted normally.
- preset asserted during ACCESS -> next edge all outputs 0, no rsp_valid; after release, req0 read completes normally with pointer=0 priority.
